// File: rtl/regfile_dual.sv
// regfile_dual: 31x32 register file, two write-back slots, four read ports.
// Define REGFILE_WR_BYPASS_EN for same-cycle write-through forwarding.
module regfile_dual #(
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_write_primary_i,
  input  logic [4:0]  reg_waddr_primary_i,
  input  logic [31:0] reg_wdata_primary_i,
  input  logic        reg_write_secondary_i,
  input  logic [4:0]  reg_waddr_secondary_i,
  input  logic [31:0] reg_wdata_secondary_i,
  input  logic [4:0]  raddr0_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  input  logic [4:0]  raddr3_i,
  output logic [31:0] rdata0_o,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  output logic [31:0] rdata3_o,
  output logic [31:0] wr_cnt_o
);

  logic        pri_en;
  logic        sec_en;
  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];
  logic [31:0] wr_cnt_q;
  logic [31:0] wr_cnt_d;
  logic [4:0]  raddr [4];
  logic [31:0] rdata [4];

  // A slot only commits when enabled and not targeting r0.
  assign pri_en = reg_write_primary_i
               && (reg_waddr_primary_i != 5'd0);
  assign sec_en = reg_write_secondary_i
               && (reg_waddr_secondary_i != 5'd0);

  // Next array state; the younger slot is applied last so it wins.
  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = regs_q[i];
      if (pri_en && (reg_waddr_primary_i == 5'(i)))
        regs_d[i] = reg_wdata_primary_i;
      if (sec_en && (reg_waddr_secondary_i == 5'(i)))
        regs_d[i] = reg_wdata_secondary_i;
    end
  end

  // Every effective write counts, even when both hit one register.
  always_comb begin
    wr_cnt_d = wr_cnt_q
             + 32'(pri_en)
             + 32'(sec_en);
  end

  // Array and counter state; reset drops any write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++)
        regs_q[i] <= RST_VAL;
      wr_cnt_q <= '0;
    end else begin
      for (int i = 1; i < 32; i++)
        regs_q[i] <= regs_d[i];
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign raddr[0] = raddr0_i;
  assign raddr[1] = raddr1_i;
  assign raddr[2] = raddr2_i;
  assign raddr[3] = raddr3_i;

  // Combinational reads; r0 is hardwired to zero.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rdata[p] = '0;
      if (raddr[p] != 5'd0) begin
        rdata[p] = regs_q[raddr[p]];
`ifdef REGFILE_WR_BYPASS_EN
        if (!rst) begin
          if (pri_en && (reg_waddr_primary_i == raddr[p]))
            rdata[p] = reg_wdata_primary_i;
          if (sec_en && (reg_waddr_secondary_i == raddr[p]))
            rdata[p] = reg_wdata_secondary_i;
        end
`endif
      end
    end
  end

  assign rdata0_o = rdata[0];
  assign rdata1_o = rdata[1];
  assign rdata2_o = rdata[2];
  assign rdata3_o = rdata[3];
  assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_regfile_dual.sv
// tb_regfile_dual: vector table, corner sequences and random stream
// against a reference model of regfile_dual.
module tb_regfile_dual;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pw, sw;
  logic [4:0]  pa, sa;
  logic [31:0] pd, sd;
  logic [4:0]  ra0, ra1, ra2, ra3;
  logic [31:0] rd0, rd1, rd2, rd3;
  logic [31:0] wr_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] m [32];
  logic [31:0] mcnt;
  bit          armed = 0;
  logic [31:0] exp_q [$];

  regfile_dual #(.RST_VAL(RV)) dut (
    .clk(clk),
    .rst(rst),
    .reg_write_primary_i(pw),
    .reg_waddr_primary_i(pa),
    .reg_wdata_primary_i(pd),
    .reg_write_secondary_i(sw),
    .reg_waddr_secondary_i(sa),
    .reg_wdata_secondary_i(sd),
    .raddr0_i(ra0),
    .raddr1_i(ra1),
    .raddr2_i(ra2),
    .raddr3_i(ra3),
    .rdata0_o(rd0),
    .rdata1_o(rd1),
    .rdata2_o(rd2),
    .rdata3_o(rd3),
    .wr_cnt_o(wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pw;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        sw;
    logic [4:0]  sa;
    logic [31:0] sd;
    logic [4:0]  ca;
    logic [31:0] er;
    logic [31:0] ec;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    logic [31:0] r;
    if (a == 5'd0) return 32'h0;
    r = m[a];
`ifdef REGFILE_WR_BYPASS_EN
    if (!rst) begin
      if (pw && pa != 0 && pa == a) r = pd;
      if (sw && sa != 0 && sa == a) r = sd;
    end
`endif
    return r;
  endfunction

  task automatic drive(input logic r,
                       input logic w0, input logic [4:0] a0,
                       input logic [31:0] d0,
                       input logic w1, input logic [4:0] a1,
                       input logic [31:0] d1);
    rst = r;
    pw = w0; pa = a0; pd = d0;
    sw = w1; sa = a1; sd = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Check reads before the edge, clock once, check the counter after.
  task automatic step();
    logic [31:0] got [4];
    #1;
    if (armed) begin
      exp_q.push_back(mread(ra0));
      exp_q.push_back(mread(ra1));
      exp_q.push_back(mread(ra2));
      exp_q.push_back(mread(ra3));
      got[0] = rd0; got[1] = rd1;
      got[2] = rd2; got[3] = rd3;
      for (int i = 0; i < 4; i++)
        chk($sformatf("rdata%0d", i), got[i], exp_q.pop_front());
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m[i] = RV;
      mcnt = 0;
      armed = 1;
    end else begin
      if (pw && pa != 0) begin m[pa] = pd; mcnt++; end
      if (sw && sa != 0) begin m[sa] = sd; mcnt++; end
    end
    #1;
    if (armed) chk("wr_cnt", wr_cnt, mcnt);
  endtask

  initial begin
    tbl[0] = '{0, 1, 5,  32'h1234_5678, 0, 0,  32'h0,
               5,  32'h1234_5678, 1};
    tbl[1] = '{0, 1, 7,  32'hAAAA_AAAA, 1, 7,  32'h5555_5555,
               7,  32'h5555_5555, 3};
    tbl[2] = '{0, 1, 0,  32'hFFFF_FFFF, 0, 0,  32'h0,
               0,  32'h0, 3};
    tbl[3] = '{0, 0, 5,  32'hBAD0_0000, 1, 0,  32'hBAD0_0001,
               5,  32'h1234_5678, 3};
    tbl[4] = '{0, 1, 1,  32'h1111_1111, 1, 2,  32'h2222_2222,
               1,  32'h1111_1111, 5};
    tbl[5] = '{0, 0, 3,  32'h3333_3333, 0, 3,  32'h3333_3333,
               3,  RV, 5};
    tbl[6] = '{0, 0, 0,  32'h0, 1, 31, 32'h3131_3131,
               31, 32'h3131_3131, 6};
    tbl[7] = '{1, 0, 0,  32'h0, 1, 9,  32'hDEAD_BEEF,
               9,  RV, 0};
    tbl[8] = '{0, 0, 0,  32'h0, 0, 0,  32'h0,
               5,  RV, 0};

    idle();
    ra0 = 0; ra1 = 0; ra2 = 0; ra3 = 0;
    rst = 1;
    sw = 1; sa = 5'd4; sd = 32'hCAFE_0004;
    step();
    chk("reset_cnt", wr_cnt, 32'h0);
    idle();
    ra0 = 4;
    #1;
    chk("reset_r4", rd0, RV);

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].rst, tbl[i].pw, tbl[i].pa, tbl[i].pd,
            tbl[i].sw, tbl[i].sa, tbl[i].sd);
      ra0 = tbl[i].ca; ra1 = tbl[i].pa;
      ra2 = tbl[i].sa; ra3 = 5'd9;
      step();
      idle();
      ra3 = tbl[i].ca;
      #1;
      chk($sformatf("vec%0d_rd", i), rd3, tbl[i].er);
      chk($sformatf("vec%0d_cnt", i), wr_cnt, tbl[i].ec);
    end

    // Collision with an older value in r7: forwarding vs array view.
    drive(0, 1, 7, 32'h0000_0077, 0, 0, 0);
    step();
    drive(0, 1, 7, 32'hAAAA_AAAA, 1, 7, 32'h5555_5555);
    ra1 = 7;
    #1;
`ifdef REGFILE_WR_BYPASS_EN
    chk("coll_same", rd1, 32'h5555_5555);
`else
    chk("coll_same", rd1, 32'h0000_0077);
`endif
    step();
    idle();
    #1;
    chk("coll_next", rd1, 32'h5555_5555);
    chk("coll_cnt", wr_cnt, 32'd3);

    // r0 write is ignored in both the same and following cycle.
    drive(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0);
    ra2 = 0;
    #1;
    chk("r0_same", rd2, 32'h0);
    step();
    idle();
    #1;
    chk("r0_next", rd2, 32'h0);
    chk("r0_cnt", wr_cnt, 32'd3);

    // Counter wraps from all-ones.
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_cnt_q;
    mcnt = 32'hFFFF_FFFF;
    chk("wrap_pre", wr_cnt, 32'hFFFF_FFFF);
    drive(0, 1, 4, 32'h0404_0404, 0, 0, 0);
    step();
    chk("wrap_cnt", wr_cnt, 32'h0);

    // Random stream, biased to low addresses for collisions.
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      pw = $urandom_range(0, 3) != 0;
      sw = $urandom_range(0, 3) != 0;
      pa = 5'($urandom_range(0, 1) ? $urandom_range(0, 7)
                                    : $urandom_range(0, 31));
      sa = 5'($urandom_range(0, 1) ? $urandom_range(0, 7)
                                    : $urandom_range(0, 31));
      pd = $urandom;
      sd = $urandom;
      ra0 = 5'($urandom_range(0, 7));
      ra1 = $urandom_range(0, 3) == 0 ? ra0
                                       : 5'($urandom_range(0, 31));
      ra2 = $urandom_range(0, 1) ? pa : sa;
      ra3 = 5'($urandom_range(0, 31));
      step();
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_left got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
